board_cell_arbiter: RTL and testbench

- Owns the single-port cell-state RAM that holds one status nibble per board button (hidden/revealed/flagged/mine count).
- Shares the RAM between three parties:
  - the per-pixel draw pipeline read port, which has absolute priority;
  - NUM_REQ game-logic requesters (click handler, flood-fill reveal, flag toggler), served round-robin with req/ack handshakes;
  - an internal clear sequencer that zeroes the board at new-game start.
- Sits between the game FSMs and the board/button draw chain, on the pixel clock.

---
 rtl/board_cell_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_board_cell_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_cell_arbiter.sv
// board_cell_arbiter
// Owns the single-port cell-state RAM (one status nibble per board button)
// and shares it between the draw pipeline (absolute priority), NUM_REQ
// game-logic requesters (round-robin, req/ack) and a clear sequencer that
// zeroes the board at new-game start.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   hblnk, vblnk      blanking flags (only with BLANK_ONLY_WR_EN)
//   clear_start       pulse: zero every cell
//   clear_busy        high while the clear sweep runs
//   draw_rd_en/addr   draw pipeline read request
//   draw_rd_data      draw read data, valid 1 cycle after draw_rd_en, else held
//   req/req_we        per-requester request and write flag
//   req_addr/wdata    flattened per-requester address / write data
//   ack               one-cycle completion pulse per requester
//   rdata             read data, valid with the ack of a read, else held
//
// Build option: define BLANK_ONLY_WR_EN to restrict requester writes and
// clear writes to blanking intervals (adds the hblnk/vblnk inputs).
//
// state  | meaning
// IDLE   | no transaction outstanding, arbitrating
// ACCESS | RAM port owned by the granted requester for one free cycle
// CLEAR  | sweeping zeros through every cell
module board_cell_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef BLANK_ONLY_WR_EN
    input  logic                      hblnk,
    input  logic                      vblnk,
`endif
    input  logic                      clear_start,
    output logic                      clear_busy,
    input  logic                      draw_rd_en,
    input  logic [ADDR_W-1:0]         draw_addr,
    output logic [DATA_W-1:0]         draw_rd_data,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_we;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               clear_pend;
    logic               draw_vld_q;
    logic               rd_vld_q;
    logic [DATA_W-1:0]  draw_hold;
    logic [DATA_W-1:0]  rdata_hold;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  ram_q;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               write_ok;
    logic               clr_go;
    logic               clear_req;

`ifdef BLANK_ONLY_WR_EN
    assign write_ok = hblnk | vblnk;
`else
    assign write_ok = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // A requester being acked this cycle still shows req high; masking it
    // keeps it from being granted twice for one handshake.
    assign eligible = req & ~ack & (~req_we | {NUM_REQ{write_ok}});

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && eligible[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign clr_go    = (state == CLEAR) && !draw_rd_en && write_ok;
    assign clear_req = clear_start | clear_pend;

    // Draw reads always own the port; an ACCESS cycle that collides with a
    // draw read simply waits for the next free cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = draw_addr;
        ram_wdata = '0;
        if (!draw_rd_en) begin
            if (state == ACCESS) begin
                ram_we    = grant_we;
                ram_addr  = grant_addr;
                ram_wdata = grant_wdata;
            end else if (clr_go) begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else
            ram_q <= mem[ram_addr];
    end

    // Both read outputs share the single RAM output register; each one shows
    // it only in the cycle after its own read and otherwise holds.
    assign draw_rd_data = draw_vld_q ? ram_q : draw_hold;
    assign rdata        = rd_vld_q   ? ram_q : rdata_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_we    <= 1'b0;
            grant_addr  <= '0;
            grant_wdata <= '0;
            clr_cnt     <= '0;
            clear_pend  <= 1'b0;
            clear_busy  <= 1'b0;
            ack         <= '0;
            draw_vld_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            draw_hold   <= '0;
            rdata_hold  <= '0;
        end else begin
            ack        <= '0;
            rd_vld_q   <= 1'b0;
            draw_vld_q <= draw_rd_en;
            draw_hold  <= draw_rd_data;
            rdata_hold <= rdata;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end else if (win_found && !draw_rd_en) begin
                        state       <= ACCESS;
                        grant_idx   <= win_idx;
                        grant_we    <= req_we[win_idx];
                        grant_addr  <= addr_arr[win_idx];
                        grant_wdata <= wdata_arr[win_idx];
                    end
                end
                ACCESS: begin
                    if (!draw_rd_en) begin
                        ack[grant_idx] <= 1'b1;
                        rd_vld_q       <= !grant_we;
                        rr_ptr         <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                        clear_pend     <= 1'b0;
                        if (clear_req) begin
                            state      <= CLEAR;
                            clr_cnt    <= '0;
                            clear_busy <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clear_pend <= clear_req;
                    end
                end
                CLEAR: begin
                    if (clear_start) begin
                        clr_cnt <= '0;
                    end else if (clr_go) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == '1) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_cell_arbiter.sv
// Self-checking bench for board_cell_arbiter: directed steps in one initial
// block, requester acks and draw reads checked against scoreboard queues fed
// from a bench-side cell memory model.
module tb_board_cell_arbiter;

    logic        clk;
    logic        rst;
`ifdef BLANK_ONLY_WR_EN
    logic        hblnk;
    logic        vblnk;
`endif
    logic        clear_start;
    logic        clear_busy;
    logic        draw_rd_en;
    logic [9:0]  draw_addr;
    logic [3:0]  draw_rd_data;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic [1:0]  ack;
    logic [3:0]  rdata;

    board_cell_arbiter #(.ADDR_W(10), .DATA_W(4), .NUM_REQ(2)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef BLANK_ONLY_WR_EN
        .hblnk        (hblnk),
        .vblnk        (vblnk),
`endif
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .draw_rd_en   (draw_rd_en),
        .draw_addr    (draw_addr),
        .draw_rd_data (draw_rd_data),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] ack_vec;
        logic       we;
        logic [3:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] draw_q[$];
    int         ack_cyc_q[$];
    logic [3:0] model_mem [1024];
    int         n_asserts = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ack_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, where inputs
    // for the next cycle are then driven.
    task automatic tick();
        logic       d_prev;
        exp_t       e;
        logic [3:0] de;
        d_prev = draw_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (d_prev) begin
            de = (draw_q.size() != 0) ? draw_q.pop_front() : 4'hx;
            chk("draw_rd_data", draw_rd_data, de);
        end
        if (ack !== 2'b00) begin
            ack_count++;
            ack_cyc_q.push_back(cyc);
            chk("ack_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ack_vec", ack, e.ack_vec);
                if (!e.we) chk("rdata", rdata, e.data);
            end
        end
    endtask

    task automatic push_exp(input int i, input logic we, input logic [9:0] addr);
        exp_t e;
        e.ack_vec = 2'(1 << i);
        e.we      = we;
        e.data    = we ? 4'h0 : model_mem[addr];
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic we, input logic [9:0] addr,
                           input logic [3:0] wd, input bit expect_ack);
        if (expect_ack) push_exp(i, we, addr);
        if (we) model_mem[addr] = wd;
        req_we[i]           = we;
        req_addr[i*10 +: 10] = addr;
        req_wdata[i*4 +: 4]  = wd;
        req[i]              = 1'b1;
    endtask

    task automatic wait_ack(input int start, output int lat);
        lat = 0;
        while (ack_count == start && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_req(input int i, input logic we, input logic [9:0] addr,
                          input logic [3:0] wd, output int lat);
        int start;
        start = ack_count;
        set_req(i, we, addr, wd, 1'b1);
        wait_ack(start, lat);
        req[i] = 1'b0;
        tick();
    endtask

    task automatic draw_read(input logic [9:0] addr);
        draw_rd_en = 1'b1;
        draw_addr  = addr;
        draw_q.push_back(model_mem[addr]);
        tick();
        draw_rd_en = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 1;
        for (int k = 0; k < 3000 && clear_busy === 1'b1; k++) begin
            tick();
            if (clear_busy === 1'b1) n++;
        end
        chk(tag, n, 1024);
        for (int a = 0; a < 1024; a++) model_mem[a] = 4'h0;
    endtask

    initial begin
        int lat;
        int start;
        rst         = 1'b1;
`ifdef BLANK_ONLY_WR_EN
        hblnk       = 1'b1;
        vblnk       = 1'b0;
`endif
        clear_start = 1'b0;
        draw_rd_en  = 1'b0;
        draw_addr   = '0;
        req         = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_draw_rd_data", draw_rd_data, 0);
        chk("rst_clear_busy", clear_busy, 0);

        // Full clear sweep, then spot-check the corners of the board.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("clear_busy_rise", clear_busy, 1);
        count_busy("clear_busy_cycles");
        draw_read(10'd0);
        draw_read(10'd513);
        draw_read(10'd1023);

        // Write then read through different requesters; draw output holds.
        do_req(0, 1'b1, 10'd37, 4'h9, lat);
        chk("wr_ack_latency", lat, 2);
        draw_read(10'd37);
        do_req(1, 1'b0, 10'd0, 4'h0, lat);
        chk("rd0_ack_latency", lat, 2);
        chk("draw_rd_data_hold", draw_rd_data, 4'h9);
        do_req(1, 1'b0, 10'd37, 4'h0, lat);
        chk("rd37_ack_latency", lat, 2);

        // Both requesters held: after reset requester 0 goes first, then
        // strict alternation at one transaction per two cycles.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        start = ack_count;
        ack_cyc_q.delete();
        set_req(0, 1'b0, 10'd37, 4'h0, 1'b1);
        set_req(1, 1'b1, 10'd40, 4'h6, 1'b1);
        push_exp(0, 1'b0, 10'd37);
        push_exp(1, 1'b1, 10'd40);
        for (int k = 0; k < 60 && ack_count - start < 4; k++) tick();
        req = 2'b00;
        tick();
        chk("rr_ack_count", ack_count - start, 4);
        if (ack_cyc_q.size() >= 4) chk("rr_ack_span", ack_cyc_q[3] - ack_cyc_q[0], 6);

        // Draw window starves the pending requester; data follows draw_addr.
        start = ack_count;
        set_req(0, 1'b0, 10'd37, 4'h0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            draw_rd_en = 1'b1;
            draw_addr  = 10'(36 + (k % 6));
            draw_q.push_back(model_mem[draw_addr]);
            tick();
        end
        chk("no_ack_in_draw_window", ack_count - start, 0);
        draw_rd_en = 1'b0;
        wait_ack(start, lat);
        chk("ack_after_draw_fall", lat, 2);
        req[0] = 1'b0;
        tick();

        // clear_start in the ACCESS cycle of a write: write acks, then clear.
        start = ack_count;
        set_req(0, 1'b1, 10'd5, 4'hF, 1'b1);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        req[0] = 1'b0;
        chk("clear_in_access_ack", ack_count - start, 1);
        chk("clear_in_access_busy", clear_busy, 1);
        count_busy("clear2_busy_cycles");
        draw_read(10'd5);
        draw_read(10'd37);
        do_req(1, 1'b0, 10'd5, 4'h0, lat);
        chk("rd5_after_clear_latency", lat, 2);

        // Reset during ACCESS: write sticks, ack is never emitted.
        set_req(0, 1'b1, 10'd9, 4'h3, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req[0] = 1'b0;
        chk("rst_mid_ack", ack, 0);
        start = ack_count;
        repeat (4) tick();
        chk("rst_mid_no_late_ack", ack_count - start, 0);
        draw_read(10'd9);

`ifdef BLANK_ONLY_WR_EN
        hblnk = 1'b0;
        start = ack_count;
        set_req(0, 1'b1, 10'd12, 4'hA, 1'b1);
        repeat (10) tick();
        chk("blank_no_ack_active", ack_count - start, 0);
        hblnk = 1'b1;
        wait_ack(start, lat);
        chk("blank_ack_latency", lat, 2);
        req[0] = 1'b0;
        tick();
        draw_read(10'd12);
`endif

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
